multicycle_control_unit: RTL

//   Sequential successor to the single-cycle decoder. FSM control for the

---
 rtl/multicycle_control_unit.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   FSM sequencer for the multi-cycle RV32I core. Each instruction is stepped
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) using a single shared
//   instruction/data memory port. The unit drives the datapath enables, the
//   ALU operation and the PC source. It also counts retired instructions and
//   traps on illegal encodings or memory timeouts.
//
//   Memory handshake: mem_req is raised in FETCH and MEM and stays high until
//   the cycle in which mem_ready is 1. That cycle completes the transfer, and
//   the FSM leaves the state on the following edge. mem_we qualifies mem_req
//   as a store. mem_ready is ignored in every other state.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   opcode, funct3            instruction fields, valid from DECODE onward
//   alu_zero                  ALU zero flag, used by branches in EXEC
//   mem_ready                 memory completed the current request
//   mem_req, mem_we, addr_sel memory request, write qualifier, address source
//   ir_write                  load the IR from memory read data
//   reg_write, mem_to_reg     register write strobe and WB source select
//   link_sel                  write PC+4 to the register file (JAL/JALR)
//   alu_src, alu_op           ALU B select; 0 ADD 1 SUB 2 R-funct 3 I-funct 4 PASS_B
//   pc_write, pc_sel          PC update strobe and source (00 +4, 01 br, 10 jal, 11 jalr)
//   trap, trap_cause          sticky fault flag; 01 illegal, 10 memory timeout
//   retire_cnt                completed instruction count (wraps)
//   state_o                   current FSM state for debug
module multicycle_control_unit #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 0,
  parameter int RETIRE_W    = 32,
  parameter int ENABLE_LUI  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                link_sel,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                pc_write,
  output logic [1:0]          pc_sel,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t              state, state_next;
  logic [6:0]          op_q;
  logic [2:0]          f3_q;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic                trap_q;
  logic [1:0]          cause_q, cause_set;
  logic                trap_set;
  logic [RETIRE_W-1:0] retire_q;
  logic                retire_inc;
  logic                dec_legal;
  logic                timeout;
  logic [2:0]          alu_op_raw;

  // Instruction class of the latched IR fields; only legal opcodes reach EXEC.
  logic is_r, is_br, is_load, is_store, is_jal, is_jalr, is_lui, br_taken;
  assign is_r     = (op_q == OP_R);
  assign is_br    = (op_q == OP_BRANCH);
  assign is_load  = (op_q == OP_LOAD);
  assign is_store = (op_q == OP_STORE);
  assign is_jal   = (op_q == OP_JAL);
  assign is_jalr  = (op_q == OP_JALR);
  assign is_lui   = (op_q == OP_LUI);
  assign br_taken = ((f3_q == 3'b000) && alu_zero) || ((f3_q == 3'b001) && !alu_zero);

  // The wait counter has already counted MEM_TIMEOUT-1 idle cycles and this
  // one is idle too. A mem_ready in the same cycle takes priority.
  assign timeout = (MEM_TIMEOUT > 0) && !mem_ready &&
                   (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: dec_legal = 1'b1;
      OP_BRANCH: dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      OP_LUI:    dec_legal = (ENABLE_LUI != 0);
      default:   dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    wait_next  = '0;
    trap_set   = 1'b0;
    cause_set  = 2'b00;
    retire_inc = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    link_sel   = 1'b0;
    alu_src    = 1'b0;
    alu_op_raw = 3'd0;
    pc_write   = 1'b0;
    pc_sel     = 2'b00;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          trap_set   = 1'b1;
          cause_set  = 2'b10;
          state_next = S_TRAP;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_next = S_EXEC;
        end else begin
          trap_set   = 1'b1;
          cause_set  = 2'b01;
          state_next = S_TRAP;
        end
      end
      S_EXEC: begin
        alu_src = !(is_r || is_br);
        if (is_r)       alu_op_raw = 3'd2;
        else if (is_br) alu_op_raw = 3'd1;
        else if (is_lui) alu_op_raw = 3'd4;
        else if (is_load || is_store || is_jal || is_jalr) alu_op_raw = 3'd0;
        else            alu_op_raw = 3'd3;
        if (is_br) begin
          pc_write   = 1'b1;
          pc_sel     = br_taken ? 2'b01 : 2'b00;
          retire_inc = 1'b1;
          state_next = S_FETCH;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write   = 1'b1;
            retire_inc = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout) begin
          trap_set   = 1'b1;
          cause_set  = 2'b10;
          state_next = S_TRAP;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        link_sel   = is_jal || is_jalr;
        pc_write   = 1'b1;
        pc_sel     = is_jal ? 2'b10 : (is_jalr ? 2'b11 : 2'b00);
        retire_inc = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase

    // While reset is held every strobe is forced low, so a request that is
    // in flight when reset arrives is withdrawn right away.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      link_sel   = 1'b0;
      alu_src    = 1'b0;
      alu_op_raw = 3'd0;
      pc_write   = 1'b0;
      pc_sel     = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      op_q     <= '0;
      f3_q     <= '0;
      wait_cnt <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      retire_q <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (state == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
      if (trap_set) begin
        trap_q  <= 1'b1;
        cause_q <= cause_set;
      end
      if (retire_inc) retire_q <= retire_q + 1'b1;
    end
  end

  assign alu_op     = ALUOP_W'(alu_op_raw);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retire_cnt = retire_q;
  assign state_o    = state;

endmodule
